// File: rtl/baud_gen_frac.sv
// Fractional baud-rate generator: oversample strobe, bit strobe and square baud clock
// from sys_clk, with a runtime divisor that is swapped in only on bit boundaries.
module baud_gen_frac #(
    parameter int DIV_W      = 16,
    parameter int FRAC_W     = 8,
    parameter int OVERSAMPLE = 16,
    parameter int DEF_INT    = 27,
    parameter int DEF_FRAC   = 32
) (
    input  logic                          sys_clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [DIV_W-1:0]              cfg_int,
    input  logic [FRAC_W-1:0]             cfg_frac,
    output logic                          tick_os,
    output logic                          tick_bit,
    output logic [$clog2(OVERSAMPLE)-1:0] os_phase,
    output logic                          baud_clk
);

    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVERSAMPLE / 2 - 1);

    function automatic logic [FRAC_W:0] frac_step(input logic [FRAC_W-1:0] acc_v,
                                                  input logic [FRAC_W-1:0] frac_v);
        return {1'b0, acc_v} + {1'b0, frac_v};
    endfunction

    logic [DIV_W-1:0]  div_int_r,  div_int_nxt_s;
    logic [FRAC_W-1:0] div_frac_r, div_frac_nxt_s;
    logic [DIV_W-1:0]  pend_int_r, pend_int_nxt_s;
    logic [FRAC_W-1:0] pend_frac_r, pend_frac_nxt_s;
    logic              pend_r, pend_nxt_s;
    logic [DIV_W-1:0]  cnt_r, cnt_nxt_s;
    logic [FRAC_W-1:0] acc_r, acc_nxt_s;
    logic              extra_r, extra_nxt_s;
    logic [OS_W-1:0]   os_cnt_r, os_cnt_nxt_s;
    logic              tick_os_r, tick_os_nxt_s;
    logic              tick_bit_r, tick_bit_nxt_s;
    logic              baud_clk_r, baud_clk_nxt_s;
    logic              cfg_ready_r, cfg_ready_nxt_s;

    logic [DIV_W:0]    period_m1_s;
    logic              period_end_s;
    logic              stall_s;
    logic              xfer_s;
    logic [FRAC_W:0]   frac_sum_s;

    // Period decode: a period lasts div_int + extra cycles; a zero divisor stalls the generator.
    always_comb begin
        period_m1_s  = {1'b0, div_int_r} + {{DIV_W{1'b0}}, extra_r} - {{DIV_W{1'b0}}, 1'b1};
        period_end_s = ({1'b0, cnt_r} == period_m1_s);
        stall_s      = (div_int_r == {DIV_W{1'b0}});
        xfer_s       = cfg_valid & cfg_ready_r;
        frac_sum_s   = frac_step(acc_r, div_frac_r);
    end

    // Next-state logic for counters, strobes, baud clock and the divisor handshake.
    always_comb begin
        div_int_nxt_s   = div_int_r;
        div_frac_nxt_s  = div_frac_r;
        pend_int_nxt_s  = pend_int_r;
        pend_frac_nxt_s = pend_frac_r;
        pend_nxt_s      = pend_r;
        cnt_nxt_s       = cnt_r;
        acc_nxt_s       = acc_r;
        extra_nxt_s     = extra_r;
        os_cnt_nxt_s    = os_cnt_r;
        tick_os_nxt_s   = 1'b0;
        tick_bit_nxt_s  = 1'b0;
        baud_clk_nxt_s  = baud_clk_r;

        if (!en) begin
            cnt_nxt_s      = {DIV_W{1'b0}};
            acc_nxt_s      = {FRAC_W{1'b0}};
            extra_nxt_s    = 1'b0;
            os_cnt_nxt_s   = {OS_W{1'b0}};
            baud_clk_nxt_s = 1'b0;
            if (pend_r) begin
                div_int_nxt_s  = pend_int_r;
                div_frac_nxt_s = pend_frac_r;
                pend_nxt_s     = 1'b0;
            end else if (xfer_s) begin
                div_int_nxt_s  = cfg_int;
                div_frac_nxt_s = cfg_frac;
            end else begin
                pend_nxt_s     = 1'b0;
            end
        end else if (stall_s) begin
            // Nothing is in flight while stalled, so a correction is applied immediately.
            if (xfer_s) begin
                div_int_nxt_s  = cfg_int;
                div_frac_nxt_s = cfg_frac;
                cnt_nxt_s      = {DIV_W{1'b0}};
                acc_nxt_s      = {FRAC_W{1'b0}};
                extra_nxt_s    = 1'b0;
            end else begin
                cnt_nxt_s      = cnt_r;
            end
        end else begin
            if (period_end_s) begin
                tick_os_nxt_s = 1'b1;
                cnt_nxt_s     = {DIV_W{1'b0}};
                {extra_nxt_s, acc_nxt_s} = frac_sum_s;
                if (os_cnt_r == OS_LAST) begin
                    os_cnt_nxt_s = {OS_W{1'b0}};
                end else begin
                    os_cnt_nxt_s = os_cnt_r + OS_W'(1);
                end
                if (os_cnt_r == OS_HALF) begin
                    baud_clk_nxt_s = 1'b1;
                end else if (os_cnt_r == OS_LAST) begin
                    baud_clk_nxt_s = 1'b0;
                end else begin
                    baud_clk_nxt_s = baud_clk_r;
                end
                if (os_cnt_r == OS_LAST) begin
                    tick_bit_nxt_s = 1'b1;
                    if (pend_r) begin
                        div_int_nxt_s  = pend_int_r;
                        div_frac_nxt_s = pend_frac_r;
                        acc_nxt_s      = {FRAC_W{1'b0}};
                        extra_nxt_s    = 1'b0;
                        pend_nxt_s     = 1'b0;
                    end else begin
                        pend_nxt_s     = 1'b0;
                    end
                end else begin
                    tick_bit_nxt_s = 1'b0;
                end
            end else begin
                cnt_nxt_s = cnt_r + DIV_W'(1);
            end
            // cfg_ready is low whenever pend is set, so a transfer here never collides with an apply.
            if (xfer_s) begin
                pend_int_nxt_s  = cfg_int;
                pend_frac_nxt_s = cfg_frac;
                pend_nxt_s      = 1'b1;
            end else begin
                pend_int_nxt_s  = pend_int_r;
            end
        end

        cfg_ready_nxt_s = ~pend_nxt_s;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            div_int_r   <= DIV_W'(DEF_INT);
            div_frac_r  <= FRAC_W'(DEF_FRAC);
            pend_int_r  <= {DIV_W{1'b0}};
            pend_frac_r <= {FRAC_W{1'b0}};
            pend_r      <= 1'b0;
            cnt_r       <= {DIV_W{1'b0}};
            acc_r       <= {FRAC_W{1'b0}};
            extra_r     <= 1'b0;
            os_cnt_r    <= {OS_W{1'b0}};
            tick_os_r   <= 1'b0;
            tick_bit_r  <= 1'b0;
            baud_clk_r  <= 1'b0;
            cfg_ready_r <= 1'b1;
        end else begin
            div_int_r   <= div_int_nxt_s;
            div_frac_r  <= div_frac_nxt_s;
            pend_int_r  <= pend_int_nxt_s;
            pend_frac_r <= pend_frac_nxt_s;
            pend_r      <= pend_nxt_s;
            cnt_r       <= cnt_nxt_s;
            acc_r       <= acc_nxt_s;
            extra_r     <= extra_nxt_s;
            os_cnt_r    <= os_cnt_nxt_s;
            tick_os_r   <= tick_os_nxt_s;
            tick_bit_r  <= tick_bit_nxt_s;
            baud_clk_r  <= baud_clk_nxt_s;
            cfg_ready_r <= cfg_ready_nxt_s;
        end
    end

    assign tick_os   = tick_os_r;
    assign tick_bit  = tick_bit_r;
    assign os_phase  = os_cnt_r;
    assign baud_clk  = baud_clk_r;
    assign cfg_ready = cfg_ready_r;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Directed bench for baud_gen_frac: one instance with default parameters (16x)
// and one with OVERSAMPLE=4 for the handshake, en/reset and stall cases.
module tb_baud_gen_frac;

    logic        sys_clk = 1'b0;
    logic        rst_n   = 1'b0;

    logic        en_a = 1'b0, cfg_valid_a = 1'b0, cfg_ready_a;
    logic [15:0] cfg_int_a = 16'd0;
    logic [7:0]  cfg_frac_a = 8'd0;
    logic        tick_os_a, tick_bit_a, baud_clk_a;
    logic [3:0]  os_phase_a;

    logic        en_b = 1'b0, cfg_valid_b = 1'b0, cfg_ready_b;
    logic [15:0] cfg_int_b = 16'd0;
    logic [7:0]  cfg_frac_b = 8'd0;
    logic        tick_os_b, tick_bit_b, baud_clk_b;
    logic [1:0]  os_phase_b;

    int n_vec = 0;
    int n_bad = 0;

    always #5 sys_clk = ~sys_clk;

    baud_gen_frac u_dut_a (
        .sys_clk(sys_clk), .rst_n(rst_n), .en(en_a),
        .cfg_valid(cfg_valid_a), .cfg_ready(cfg_ready_a),
        .cfg_int(cfg_int_a), .cfg_frac(cfg_frac_a),
        .tick_os(tick_os_a), .tick_bit(tick_bit_a),
        .os_phase(os_phase_a), .baud_clk(baud_clk_a)
    );

    baud_gen_frac #(.OVERSAMPLE(4)) u_dut_b (
        .sys_clk(sys_clk), .rst_n(rst_n), .en(en_b),
        .cfg_valid(cfg_valid_b), .cfg_ready(cfg_ready_b),
        .cfg_int(cfg_int_b), .cfg_frac(cfg_frac_b),
        .tick_os(tick_os_b), .tick_bit(tick_bit_b),
        .os_phase(os_phase_b), .baud_clk(baud_clk_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    // Cycles until the next tick_os is seen; returns the bound on timeout.
    task automatic wait_tick_a(output int cyc);
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (!tick_os_a && cyc < 2000);
    endtask

    task automatic wait_tick_b(output int cyc);
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (!tick_os_b && cyc < 2000);
    endtask

    task automatic cfg_b(input int i, input int f);
        cfg_int_b   = 16'(i);
        cfg_frac_b  = 8'(f);
        cfg_valid_b = 1'b1;
        step();
        cfg_valid_b = 1'b0;
    endtask

    initial begin
        int cyc, total, n28, bad_gap, nt;
        int gaps35 [6] = '{3, 4, 3, 4, 3, 4};

        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Reset state
        chk("rst_tick_os", 32'(tick_os_a), 32'd0);
        chk("rst_tick_bit", 32'(tick_bit_a), 32'd0);
        chk("rst_baud_clk", 32'(baud_clk_a), 32'd0);
        chk("rst_os_phase", 32'(os_phase_a), 32'd0);
        chk("rst_cfg_ready", 32'(cfg_ready_a), 32'd1);

        // Default 27 + 32/256 divisor, 256 tick intervals
        en_a = 1'b1;
        wait_tick_a(cyc);
        chk("def_first_tick", 32'(cyc), 32'd27);
        total = 0; n28 = 0; bad_gap = 0;
        for (int i = 0; i < 256; i++) begin
            wait_tick_a(cyc);
            total += cyc;
            if (cyc == 28) n28++;
            else if (cyc != 27) bad_gap++;
        end
        chk("def_gap_range", 32'(bad_gap), 32'd0);
        chk("def_n28", 32'(n28), 32'd32);
        chk("def_total", 32'(total), 32'd6944);
        en_a = 1'b0;

        // OVERSAMPLE=4, int=4 frac=0 loaded while idle
        cfg_b(4, 0);
        chk("idle_cfg_ready", 32'(cfg_ready_b), 32'd1);
        en_b = 1'b1;
        wait_tick_b(cyc);
        chk("os4_first_tick", 32'(cyc), 32'd4);
        for (int n = 1; n <= 8; n++) begin
            if (n > 1) begin
                wait_tick_b(cyc);
                chk("os4_gap", 32'(cyc), 32'd4);
            end
            chk("os4_phase", 32'(os_phase_b), 32'(n % 4));
            chk("os4_tick_bit", 32'(tick_bit_b), 32'((n % 4) == 0));
            chk("os4_baud", 32'(baud_clk_b), 32'(((n % 4) == 2) || ((n % 4) == 3)));
        end
        step();
        chk("os4_tick_one_cycle", 32'(tick_os_b), 32'd0);
        en_b = 1'b0;
        step();

        // int=3 frac=128: periods 3,3,4,3,4,...
        cfg_b(3, 128);
        en_b = 1'b1;
        wait_tick_b(cyc);
        chk("frac_first_tick", 32'(cyc), 32'd3);
        total = 0;
        for (int i = 0; i < 6; i++) begin
            wait_tick_b(cyc);
            chk("frac_gap", 32'(cyc), 32'(gaps35[i]));
            total += cyc;
        end
        chk("frac_sum6", 32'(total), 32'd21);
        en_b = 1'b0;
        step();

        // Runtime change to int=5 in the middle of a bit
        cfg_b(4, 0);
        en_b = 1'b1;
        wait_tick_b(cyc);
        wait_tick_b(cyc);
        chk("mid_phase", 32'(os_phase_b), 32'd2);
        cfg_b(5, 0);
        chk("pend_ready_low", 32'(cfg_ready_b), 32'd0);
        wait_tick_b(cyc);
        chk("old_div_gap_a", 32'(cyc + 1), 32'd4);
        chk("pend_ready_still_low", 32'(cfg_ready_b), 32'd0);
        wait_tick_b(cyc);
        chk("old_div_gap_b", 32'(cyc), 32'd4);
        chk("apply_tick_bit", 32'(tick_bit_b), 32'd1);
        chk("apply_ready_back", 32'(cfg_ready_b), 32'd1);
        for (int i = 0; i < 4; i++) begin
            wait_tick_b(cyc);
            chk("new_div_gap", 32'(cyc), 32'd5);
        end

        // en drop mid-bit: outputs clear, divisor kept
        wait_tick_b(cyc);
        wait_tick_b(cyc);
        step();
        en_b = 1'b0;
        step();
        chk("enlow_tick_os", 32'(tick_os_b), 32'd0);
        chk("enlow_tick_bit", 32'(tick_bit_b), 32'd0);
        chk("enlow_baud", 32'(baud_clk_b), 32'd0);
        chk("enlow_phase", 32'(os_phase_b), 32'd0);
        en_b = 1'b1;
        wait_tick_b(cyc);
        chk("enlow_kept_div", 32'(cyc), 32'd5);

        // rst_n drop mid-bit with a pending divisor
        wait_tick_b(cyc);
        step();
        cfg_b(7, 0);
        chk("rst_pend_ready_low", 32'(cfg_ready_b), 32'd0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rst2_cfg_ready", 32'(cfg_ready_b), 32'd1);
        chk("rst2_phase", 32'(os_phase_b), 32'd0);
        chk("rst2_baud", 32'(baud_clk_b), 32'd0);
        wait_tick_b(cyc);
        chk("rst2_default_div", 32'(cyc), 32'd27);
        for (int i = 0; i < 5; i++) begin
            wait_tick_b(cyc);
            chk("rst2_no_pend_gap", 32'(cyc), 32'd27);
        end
        en_b = 1'b0;
        step();

        // int=0 stalls, then int=2 restarts
        cfg_b(0, 0);
        en_b = 1'b1;
        nt = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (tick_os_b) nt++;
        end
        chk("stall_no_ticks", 32'(nt), 32'd0);
        chk("stall_cfg_ready", 32'(cfg_ready_b), 32'd1);
        cfg_b(2, 0);
        wait_tick_b(cyc);
        chk("stall_resume_bounded", 32'(cyc < 2000), 32'd1);
        for (int i = 0; i < 4; i++) begin
            wait_tick_b(cyc);
            chk("stall_resume_gap", 32'(cyc), 32'd2);
        end
        en_b = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
